// File: rtl/dct_mac_if.sv
// Sample-in / coefficient-out handshake bundle for the
// 1-D transform engine.
interface dct_mac_if #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int OUT_WIDTH  = 12
);
    localparam int IW = $clog2(N);

    logic signed [DATA_WIDTH-1:0] in_data;
    logic                         in_valid;
    logic                         in_last;
    logic                         in_ready;
    logic                         inv;
    logic signed [OUT_WIDTH-1:0]  out_data;
    logic [IW-1:0]                out_idx;
    logic                         out_last;
    logic                         out_sat;
    logic                         out_valid;
    logic                         out_ready;
    logic                         err;

    modport master (
        output in_data, in_valid, in_last, inv, out_ready,
        input  in_ready, out_data, out_idx, out_last,
        input  out_sat, out_valid, err
    );

    modport slave (
        input  in_data, in_valid, in_last, inv, out_ready,
        output in_ready, out_data, out_idx, out_last,
        output out_sat, out_valid, err
    );
endinterface

// File: rtl/dct_mac_engine.sv
// N-point matrix-vector MAC engine with streaming input and a
// double-buffered, rounded and saturated output bank.
module dct_mac_engine #(
    parameter int N          = 8,
    parameter int DATA_WIDTH = 8,
    parameter int COEF_WIDTH = 8,
    parameter int OUT_WIDTH  = 12,
    parameter int SHIFT      = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N*N*COEF_WIDTH-1:0]    coef,
    dct_mac_if.slave                     bus
);
    localparam int IW    = $clog2(N);
    localparam int PW    = DATA_WIDTH + COEF_WIDTH;
    localparam int ACC_W = PW + IW;
    localparam int RW    = ACC_W + 1;
    localparam int WW    = (RW > OUT_WIDTH ? RW : OUT_WIDTH) + 1;
    localparam logic [IW-1:0] LAST = IW'(N - 1);
    localparam int RSH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [RW-1:0] RND =
        (SHIFT > 0) ? (RW'(1) << RSH) : '0;
    localparam logic signed [WW-1:0] MAXV =
        {{(WW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [WW-1:0] MINV = ~MAXV;

    logic [IW-1:0] idx_q, idx_d;
    logic [IW-1:0] out_idx_q, out_idx_d;
    logic          inv_q, inv_d;
    logic          full_q, full_d;
    logic          err_q, err_d;

    logic signed [ACC_W-1:0] acc_q  [N];
    logic signed [ACC_W-1:0] acc_d  [N];
    logic signed [ACC_W-1:0] bank_q [N];
    logic signed [ACC_W-1:0] bank_d [N];

    logic signed [COEF_WIDTH-1:0] csel [N];
    logic signed [PW-1:0]         prod [N];

    logic mode;
    logic accept;
    logic drain;
    logic drain_end;

    assign drain     = full_q && bus.out_ready;
    assign drain_end = drain && (out_idx_q == LAST);
    assign bus.in_ready = !((idx_q == LAST) && full_q && !drain_end);
    assign accept    = bus.in_valid && bus.in_ready;
    assign mode      = (idx_q == '0) ? bus.inv : inv_q;

    // Inverse mode walks the transposed matrix: C[i][k] instead of C[k][i].
    always_comb begin
        for (int k = 0; k < N; k++) begin
            if (mode)
                csel[k] = coef[(int'(idx_q)*N + k)*COEF_WIDTH +: COEF_WIDTH];
            else
                csel[k] = coef[(k*N + int'(idx_q))*COEF_WIDTH +: COEF_WIDTH];
            prod[k] = bus.in_data * csel[k];
        end
    end

    always_comb begin
        idx_d     = idx_q;
        out_idx_d = out_idx_q;
        inv_d     = inv_q;
        full_d    = full_q;
        err_d     = 1'b0;
        acc_d     = acc_q;
        bank_d    = bank_q;

        if (drain) begin
            out_idx_d = out_idx_q + 1'b1;
            if (out_idx_q == LAST)
                full_d = 1'b0;
        end

        if (accept) begin
            if (idx_q == '0)
                inv_d = bus.inv;
            if (idx_q == LAST) begin
                for (int k = 0; k < N; k++) begin
                    bank_d[k] = acc_q[k] + {{IW{prod[k][PW-1]}}, prod[k]};
                    acc_d[k]  = '0;
                end
                idx_d     = '0;
                out_idx_d = '0;
                full_d    = 1'b1;
                err_d     = !bus.in_last;
            end else if (bus.in_last) begin
                for (int k = 0; k < N; k++)
                    acc_d[k] = '0;
                idx_d = '0;
                err_d = 1'b1;
            end else begin
                for (int k = 0; k < N; k++)
                    acc_d[k] = acc_q[k] + {{IW{prod[k][PW-1]}}, prod[k]};
                idx_d = idx_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q     <= '0;
            out_idx_q <= '0;
            inv_q     <= 1'b0;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
            for (int k = 0; k < N; k++) begin
                acc_q[k]  <= '0;
                bank_q[k] <= '0;
            end
        end else begin
            idx_q     <= idx_d;
            out_idx_q <= out_idx_d;
            inv_q     <= inv_d;
            full_q    <= full_d;
            err_q     <= err_d;
            acc_q     <= acc_d;
            bank_q    <= bank_d;
        end
    end

    logic signed [ACC_W-1:0] sel;
    logic signed [RW-1:0]    sum;
    logic signed [RW-1:0]    shr;
    logic signed [WW-1:0]    r;
    logic signed [OUT_WIDTH-1:0] odata;
    logic                    osat;

    // Round half toward +inf, then clamp to the output range.
    always_comb begin
        sel = bank_q[out_idx_q];
        sum = {sel[ACC_W-1], sel} + RND;
        shr = sum >>> SHIFT;
        r   = {{(WW-RW){shr[RW-1]}}, shr};
        osat  = 1'b0;
        odata = r[OUT_WIDTH-1:0];
        if (r > MAXV) begin
            osat  = 1'b1;
            odata = MAXV[OUT_WIDTH-1:0];
        end else if (r < MINV) begin
            osat  = 1'b1;
            odata = MINV[OUT_WIDTH-1:0];
        end
    end

    assign bus.out_valid = full_q;
    assign bus.out_idx   = out_idx_q;
    assign bus.out_last  = (out_idx_q == LAST);
    assign bus.out_data  = odata;
    assign bus.out_sat   = full_q && osat;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_dct_mac_engine.sv
// Directed bench for dct_mac_engine: two N=4 instances,
// SHIFT=0 and SHIFT=2, with hand-computed expected outputs.
module tb_dct_mac_engine;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [127:0] coef0;
    logic [127:0] coef1;
    int vecs = 0;
    int errs = 0;

    always #5 clk = ~clk;

    dct_mac_if #(.N(4), .DATA_WIDTH(8), .OUT_WIDTH(12)) b0 ();
    dct_mac_if #(.N(4), .DATA_WIDTH(8), .OUT_WIDTH(12)) b1 ();

    dct_mac_engine #(
        .N(4), .DATA_WIDTH(8), .COEF_WIDTH(8),
        .OUT_WIDTH(12), .SHIFT(0)
    ) u0 (
        .clk(clk), .rst_n(rst_n), .coef(coef0), .bus(b0.slave)
    );

    dct_mac_engine #(
        .N(4), .DATA_WIDTH(8), .COEF_WIDTH(8),
        .OUT_WIDTH(12), .SHIFT(2)
    ) u1 (
        .clk(clk), .rst_n(rst_n), .coef(coef1), .bus(b1.slave)
    );

    function automatic logic [127:0] mk_all(input logic [7:0] v);
        logic [127:0] c;
        for (int i = 0; i < 16; i++) c[i*8 +: 8] = v;
        return c;
    endfunction

    function automatic logic [127:0] mk_ident();
        logic [127:0] c;
        c = '0;
        for (int i = 0; i < 4; i++) c[(i*4+i)*8 +: 8] = 8'd1;
        return c;
    endfunction

    task automatic chk(input string tag,
                       input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int u, input logic v, input int d,
                         input logic l, input logic iv);
        if (u == 0) begin
            b0.in_valid = v; b0.in_data = 8'(d);
            b0.in_last = l; b0.inv = iv;
        end else begin
            b1.in_valid = v; b1.in_data = 8'(d);
            b1.in_last = l; b1.inv = iv;
        end
    endtask

    // Mode is driven only on sample 0; later samples carry the opposite.
    task automatic send(input int u, input int n,
                        input int a0, input int a1,
                        input int a2, input int a3,
                        input int lastpos, input logic inv0);
        int a[4];
        a = '{a0, a1, a2, a3};
        for (int j = 0; j < n; j++) begin
            drive(u, 1'b1, a[j], j == lastpos, (j == 0) ? inv0 : !inv0);
            step();
        end
        drive(u, 1'b0, 0, 1'b0, 1'b0);
    endtask

    task automatic expect_blk(input int u, input string nm,
                              input int e0, input int e1,
                              input int e2, input int e3,
                              input logic [3:0] s);
        int e[4];
        logic signed [31:0] ov, oi, od, os, ol;
        e = '{e0, e1, e2, e3};
        for (int k = 0; k < 4; k++) begin
            if (u == 0) begin
                ov = b0.out_valid; oi = b0.out_idx; od = b0.out_data;
                os = b0.out_sat; ol = b0.out_last;
            end else begin
                ov = b1.out_valid; oi = b1.out_idx; od = b1.out_data;
                os = b1.out_sat; ol = b1.out_last;
            end
            chk($sformatf("%s_valid%0d", nm, k), ov, 1);
            chk($sformatf("%s_idx%0d", nm, k), oi, k);
            chk($sformatf("%s_data%0d", nm, k), od, e[k]);
            chk($sformatf("%s_sat%0d", nm, k), os, {31'd0, s[k]});
            chk($sformatf("%s_last%0d", nm, k), ol, (k == 3) ? 1 : 0);
            step();
        end
    endtask

    initial begin
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        drive(1, 1'b0, 0, 1'b0, 1'b0);
        b0.out_ready = 1'b1;
        b1.out_ready = 1'b1;
        coef0 = mk_all(8'd1);
        coef1 = mk_ident();

        step(); step();
        rst_n = 1'b1;
        step(); step(); step();
        chk("rst_valid", b0.out_valid, 0);
        chk("rst_err", b0.err, 0);
        chk("rst_ready", b0.in_ready, 1);

        send(0, 4, 1, 2, 3, 4, 3, 1'b0);
        expect_blk(0, "fwd", 10, 10, 10, 10, 4'h0);
        chk("fwd_idle", b0.out_valid, 0);

        coef0 = mk_ident();
        coef0[(0*4+1)*8 +: 8] = 8'd2;
        send(0, 4, 1, 1, 1, 1, 3, 1'b0);
        expect_blk(0, "inv0", 3, 1, 1, 1, 4'h0);
        send(0, 4, 1, 1, 1, 1, 3, 1'b1);
        expect_blk(0, "inv1", 1, 3, 1, 1, 4'h0);

        coef0 = mk_all(8'd127);
        send(0, 4, 127, 127, 127, 127, 3, 1'b0);
        expect_blk(0, "satp", 2047, 2047, 2047, 2047, 4'hF);
        send(0, 4, -128, -128, -128, -128, 3, 1'b0);
        expect_blk(0, "satn", -2048, -2048, -2048, -2048, 4'hF);

        send(1, 4, 6, -6, 2, -2, 3, 1'b0);
        expect_blk(1, "rnd", 2, -1, 1, 0, 4'h0);

        coef0 = mk_all(8'd1);
        b0.out_ready = 1'b0;
        for (int j = 0; j < 4; j++) begin
            drive(0, 1'b1, 1, j == 3, 1'b0);
            #1 chk($sformatf("bp_a_rdy%0d", j), b0.in_ready, 1);
            step();
        end
        for (int j = 0; j < 3; j++) begin
            drive(0, 1'b1, 2, 1'b0, 1'b0);
            #1 chk($sformatf("bp_b_rdy%0d", j), b0.in_ready, 1);
            step();
        end
        drive(0, 1'b1, 2, 1'b1, 1'b0);
        #1 chk("bp_stall0", b0.in_ready, 0);
        step();
        chk("bp_stall1", b0.in_ready, 0);
        chk("bp_hold_valid", b0.out_valid, 1);
        chk("bp_hold_idx", b0.out_idx, 0);
        chk("bp_hold_data", b0.out_data, 4);
        step();
        b0.out_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("bp_dr_idx%0d", k), b0.out_idx, k);
            chk($sformatf("bp_dr_data%0d", k), b0.out_data, 4);
            chk($sformatf("bp_dr_rdy%0d", k), b0.in_ready,
                (k == 3) ? 1 : 0);
            step();
        end
        drive(0, 1'b0, 0, 1'b0, 1'b0);
        expect_blk(0, "bp_b", 8, 8, 8, 8, 4'h0);
        chk("bp_idle", b0.out_valid, 0);

        send(0, 2, 5, 5, 0, 0, 1, 1'b0);
        chk("frm_err", b0.err, 1);
        chk("frm_novalid", b0.out_valid, 0);
        step();
        chk("frm_err_clr", b0.err, 0);
        chk("frm_novalid2", b0.out_valid, 0);
        send(0, 4, 1, 2, 3, 4, 3, 1'b0);
        expect_blk(0, "frm_next", 10, 10, 10, 10, 4'h0);

        send(0, 4, 1, 1, 1, 1, -1, 1'b0);
        chk("nolast_err", b0.err, 1);
        expect_blk(0, "nolast", 4, 4, 4, 4, 4'h0);

        send(0, 4, 1, 2, 3, 4, 3, 1'b0);
        chk("rd_valid", b0.out_valid, 1);
        step();
        chk("rd_idx1", b0.out_idx, 1);
        rst_n = 1'b0;
        step();
        chk("rd_valid_rst", b0.out_valid, 0);
        chk("rd_ready_rst", b0.in_ready, 1);
        chk("rd_idx_rst", b0.out_idx, 0);
        rst_n = 1'b1;
        step(); step();
        chk("rd_stale", b0.out_valid, 0);
        chk("rd_err", b0.err, 0);
        send(0, 4, 4, 3, 2, 1, 3, 1'b0);
        expect_blk(0, "rd_after", 10, 10, 10, 10, 4'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/dct_mac_engine.md
Name: dct_mac_engine

Overview:
- Parametrised N-point 1-D transform engine: y[k] = sum over n of C[k][n]*x[n] (forward), or y[k] = sum over n of C[n][k]*x[n] (inverse, transposed matrix).
- Streams one sample per cycle in and one coefficient per cycle out, with valid/ready handshakes on both sides and a double-buffered output bank so the next block accumulates while the previous one drains.
- Replaces fixed 4-lane, unsigned, no-handshake x->z / z->y arrays as the row/column stage of the 2-D DCT pipeline.

Parameters:
- N, 8: transform points per block (>=2, power of two).
- DATA_WIDTH, 8: signed input sample width.
- COEF_WIDTH, 8: signed coefficient width.
- OUT_WIDTH, 12: signed output width after rounding and saturation.
- SHIFT, 0: arithmetic right shift applied to each sum (0 = no rounding).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- coef  in  N*N*COEF_WIDTH  signed C[k][n] at bits (k*N+n)*COEF_WIDTH +: COEF_WIDTH; static while a block is in flight.
- inv  in  1  mode select (1 = transposed matrix); sampled with sample index 0.
- in_data  in  DATA_WIDTH  signed sample.
- in_valid  in  1  sample valid.
- in_last  in  1  marks the final sample of a block.
- in_ready  out  1  engine accepts the sample this cycle.
- out_data  out  OUT_WIDTH  signed result y[out_idx].
- out_idx  out  clog2(N)  output coefficient index.
- out_last  out  1  high with out_idx == N-1.
- out_sat  out  1  out_data was clipped.
- out_valid  out  1  output valid.
- out_ready  in  1  downstream accepts the output.
- err  out  1  one-cycle framing-error pulse.

Behaviour:
- Reset: rst_n is synchronous, active-low; clock clk. On reset, the input index, output index, accumulators, bank-full flag, out_valid, out_sat and err all clear to 0. in_ready is 1 after reset. Reset mid-block discards all partial and undrained data.
- Accept: a sample is accepted when in_valid && in_ready. Sample index i runs 0..N-1. Mode is latched when i == 0 and holds for the whole block.
- Accumulate: N accumulators of ACC_W = DATA_WIDTH + COEF_WIDTH + clog2(N) bits, all signed. Per accepted sample, acc[k] += x * (inv ? C[i][k] : C[k][i]). No overflow is possible at ACC_W.
- Block end: on accepting i == N-1, the final sums (acc + product) load into the output bank on the same edge. Accumulators and i clear on that edge. bank_full sets, out_idx goes to 0, and out_valid is 1 on the next cycle. Latency from the last input to the first output is 1 cycle.
- Drain: on each out_valid && out_ready, out_idx increments. On the handshake at out_idx == N-1, bank_full clears. out_data, out_sat and out_last are derived from bank[out_idx] and held stable while stalled.
- Back-pressure rule: in_ready = !(i == N-1 && bank_full && !(out_valid && out_ready && out_last)).
  - Samples 0..N-2 of the next block are always accepted during a drain.
  - The combinational path from out_ready to in_ready is intended.
  - Simultaneous final output handshake and final input acceptance reloads the bank with no bubble.
- Rounding: r = (acc + (SHIFT > 0 ? 1 << (SHIFT-1) : 0)) >>> SHIFT, i.e. round half toward +inf.
- Saturation: r is clamped to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1]. out_sat = 1 when the clamp was applied.
- Framing errors:
  - in_last accepted with i < N-1: err pulses, the partial block is dropped, and i and the accumulators clear.
  - in_last low at i == N-1: err pulses, but the block is emitted normally.
  - err is registered, so it is high the cycle after the offending acceptance.
- in_valid low: no state change on the input side. Gaps are allowed anywhere in a block.

Test Plan:
- Reset/idle: N=4, after reset and 3 idle cycles -> out_valid=0, err=0, in_ready=1.
- Forward: N=4, C = all ones, SHIFT=0, x = 1,2,3,4 back-to-back with in_last on 4 -> starting the next cycle, four outputs of 10 with out_idx 0..3 and out_last on idx 3, out_ready held high.
- Inverse: N=4, C = identity except C[0][1]=2, x = 1,1,1,1 -> inv=0 gives 3,1,1,1; inv=1 gives 1,3,1,1.
- Rounding/saturation: N=4, C = all 127, x = 127 x4 -> 2047 with out_sat=1; x = -128 x4 -> -2048 with out_sat=1. With SHIFT=2, acc 6 -> 2 and acc -6 -> -1, out_sat=0.
- Back-pressure: out_ready=0, feed two blocks -> in_ready drops only at the second block's sample 3. Release out_ready -> in_ready rises in the cycle the idx-3 handshake occurs, and the second block follows with no gap.
- Framing and reset: in_last on sample 1 -> err pulse, no output, the next block computes correctly. rst_n low during a drain -> out_valid=0 on the next cycle and no stale outputs afterwards.
